// File: rtl/iconn_lower_distributor.sv
// Lower-level interconnect distributor: routes each incoming flit by one address bit
// into one of two independent 2-entry FIFOs, each presenting its oldest flit downstream.
module iconn_lower_distributor #(
    parameter int PORT_NUM        = 2,
    parameter int NODE_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH      = 32,
    parameter int ROUTE_BIT       = NODE_ADDR_WIDTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NODE_ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic [NODE_ADDR_WIDTH-1:0] aout [0:PORT_NUM-1],
    output logic [DATA_WIDTH-1:0]      dout [0:PORT_NUM-1],
    output logic [PORT_NUM-1:0]        aout_valid,
    input  logic [PORT_NUM-1:0]        aout_ready,
    output logic [1:0]                 occupancy [0:PORT_NUM-1]
);

    localparam int ENTRY_W = NODE_ADDR_WIDTH + DATA_WIDTH;

    logic       tgt_s;
    logic [1:0] occ_s [0:PORT_NUM-1];

    // Target port selection and admission; a full target refuses even if it pops this cycle.
    always_comb begin
        tgt_s    = in_addr[ROUTE_BIT];
        in_ready = (occ_s[tgt_s] != 2'd2);
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        logic [ENTRY_W-1:0] mem_q [0:1];
        logic [ENTRY_W-1:0] head_s;
        logic               wr_ptr_q;
        logic               wr_ptr_d;
        logic               rd_ptr_q;
        logic               rd_ptr_d;
        logic [1:0]         occ_q;
        logic [1:0]         occ_d;
        logic               push_s;
        logic               pop_s;

        // Handshake decode and pointer/occupancy next state.
        always_comb begin
            push_s   = in_valid && in_ready && (tgt_s == 1'(p));
            pop_s    = (occ_q != 2'd0) && aout_ready[p];
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            occ_d    = occ_q;
            if (push_s) begin
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end

        // FIFO control state; cleared asynchronously so stale flits can never reappear.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                occ_q    <= 2'd0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                occ_q    <= occ_d;
            end
        end

        // Entry storage carries no reset; contents only matter while counted in occupancy.
        always_ff @(posedge clk) begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= {in_addr, in_data};
            end
        end

        assign head_s        = mem_q[rd_ptr_q];
        assign aout[p]       = head_s[ENTRY_W-1:DATA_WIDTH];
        assign dout[p]       = head_s[DATA_WIDTH-1:0];
        assign aout_valid[p] = (occ_q != 2'd0);
        assign occupancy[p]  = occ_q;
        assign occ_s[p]      = occ_q;
    end

endmodule

// File: tb/tb_iconn_lower_distributor.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_iconn_lower_distributor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic [4:0]  aout [0:1];
    logic [31:0] dout [0:1];
    logic [1:0]  aout_valid;
    logic [1:0]  aout_ready;
    logic [1:0]  occupancy [0:1];

    int total = 0;
    int bad   = 0;

    logic [36:0] q0 [$];
    logic [36:0] q1 [$];

    iconn_lower_distributor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .aout      (aout),
        .dout      (dout),
        .aout_valid(aout_valid),
        .aout_ready(aout_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int qsize(input int p);
        return (p == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [36:0] qhead(input int p);
        return (p == 0) ? q0[0] : q1[0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one FIFO queue per port, updated from pre-edge state at each edge.
    always @(posedge clk) begin
        int  tgt;
        bit  push;
        bit  pop0;
        bit  pop1;
        if (rst_n) begin
            tgt  = int'(in_addr[4]);
            push = in_valid && (qsize(tgt) < 2);
            pop0 = (q0.size() != 0) && aout_ready[0];
            pop1 = (q1.size() != 0) && aout_ready[1];
            if (pop0) void'(q0.pop_front());
            if (pop1) void'(q1.pop_front());
            if (push) begin
                if (tgt == 0) q0.push_back({in_addr, in_data});
                else          q1.push_back({in_addr, in_data});
            end
        end else begin
            q0.delete();
            q1.delete();
        end
    end

    always @(negedge rst_n) begin
        q0.delete();
        q1.delete();
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        logic [36:0] h;
        chk("model_in_ready", {63'd0, in_ready}, {63'd0, (qsize(int'(in_addr[4])) < 2)});
        for (int p = 0; p < 2; p++) begin
            chk("model_valid", {63'd0, aout_valid[p]}, {63'd0, (qsize(p) != 0)});
            chk("model_occ", {62'd0, occupancy[p]}, 64'(qsize(p)));
            if (qsize(p) != 0) begin
                h = qhead(p);
                chk("model_aout", {59'd0, aout[p]}, {59'd0, h[36:32]});
                chk("model_dout", {32'd0, dout[p]}, {32'd0, h[31:0]});
            end
        end
    end

    // Drive one cycle of inputs just after an edge, return at the following falling edge.
    task automatic tick(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [1:0] r);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_addr    = a;
        in_data    = d;
        aout_ready = r;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_addr    = 5'd0;
        in_data    = 32'd0;
        aout_ready = 2'b00;
        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_valid", {62'd0, aout_valid}, 64'd0);
        #5 rst_n = 1'b1;

        // Routing by address bit 4
        tick(1'b1, 5'h13, 32'hA5, 2'b00);
        chk("route_ready", {63'd0, in_ready}, 64'd1);
        tick(1'b0, 5'h00, 32'h0, 2'b00);
        chk("route_valid", {62'd0, aout_valid}, 64'h2);
        chk("route_aout1", {59'd0, aout[1]}, 64'h13);
        chk("route_dout1", {32'd0, dout[1]}, 64'hA5);
        chk("route_occ1", {62'd0, occupancy[1]}, 64'd1);

        // Fill port 0, third flit refused, other port still accepts
        tick(1'b1, 5'h01, 32'h101, 2'b00);
        tick(1'b1, 5'h02, 32'h102, 2'b00);
        tick(1'b1, 5'h03, 32'h103, 2'b00);
        chk("full_ready0", {63'd0, in_ready}, 64'd0);
        chk("full_occ0", {62'd0, occupancy[0]}, 64'd2);
        tick(1'b1, 5'h11, 32'h111, 2'b00);
        chk("full_ready1", {63'd0, in_ready}, 64'd1);

        // Full with pop in the same cycle: no bypass, push lands next cycle
        tick(1'b1, 5'h04, 32'h104, 2'b01);
        chk("fullpop_ready", {63'd0, in_ready}, 64'd0);
        chk("fullpop_head", {59'd0, aout[0]}, 64'h01);
        tick(1'b1, 5'h04, 32'h104, 2'b01);
        chk("fullpop_occ0", {62'd0, occupancy[0]}, 64'd1);
        chk("fullpop_ready2", {63'd0, in_ready}, 64'd1);
        chk("order_first", {59'd0, aout[0]}, 64'h02);
        tick(1'b0, 5'h00, 32'h0, 2'b00);
        chk("order_second", {59'd0, aout[0]}, 64'h04);
        chk("order_occ0", {62'd0, occupancy[0]}, 64'd1);

        // Streaming alternating ports with both consumers ready
        for (int i = 0; i < 4; i++) tick(1'b0, 5'h00, 32'h0, 2'b11);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, (i % 2 == 1) ? 5'(5'h10 + i) : 5'(i), 32'(32'h200 + i), 2'b11);
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
            chk("stream_occ0", {63'd0, (occupancy[0] > 2'd1)}, 64'd0);
            chk("stream_occ1", {63'd0, (occupancy[1] > 2'd1)}, 64'd0);
        end
        tick(1'b0, 5'h00, 32'h0, 2'b11);
        tick(1'b0, 5'h00, 32'h0, 2'b00);
        chk("stream_drained", {62'd0, aout_valid}, 64'd0);

        // Reset mid-operation with both FIFOs full
        tick(1'b1, 5'h05, 32'h305, 2'b00);
        tick(1'b1, 5'h06, 32'h306, 2'b00);
        tick(1'b1, 5'h15, 32'h315, 2'b00);
        tick(1'b1, 5'h16, 32'h316, 2'b00);
        tick(1'b1, 5'h07, 32'h307, 2'b00);
        chk("pre_rst_occ0", {62'd0, occupancy[0]}, 64'd2);
        chk("pre_rst_occ1", {62'd0, occupancy[1]}, 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {62'd0, aout_valid}, 64'd0);
        chk("rst_mid_occ0", {62'd0, occupancy[0]}, 64'd0);
        chk("rst_mid_occ1", {62'd0, occupancy[1]}, 64'd0);
        chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick(1'b0, 5'h00, 32'h0, 2'b11);
        tick(1'b0, 5'h00, 32'h0, 2'b11);
        chk("post_rst_valid", {62'd0, aout_valid}, 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            tick(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, 2'($urandom));
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 5'h00, 32'h0, 2'b11);
        chk("final_empty", {62'd0, aout_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
